rob_tag_allocator: RTL and testbench
====================================

Name: rob_tag_allocator

Overview:
- Controller that allocates ROB tags to instructions in the rename stage and retires them at commit.
- Sequences the register status file: drives its rename-side write (`we`, `destRegR`, `destROB`) and its commit-side inputs (`validCommit`, `commitROB`, `regCommit`).
- Circular FIFO of tags with head/tail pointers, occupancy count and a per-entry destination table.
- Sits between decode/rename and the register status file / ROB.

Parameters:
- REG, 4, MSB index of register specifier (32 architectural registers).
- ROB, 2, MSB index of ROB tag (8 entries).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset.
- flush  in  1  pipeline flush request from committing instruction; honoured at next posedge.
- renValid  in  1  rename-stage instruction present.
- renRegWrite  in  1  instruction writes a destination register.
- renDest  in  REG+1  destination register.
- renReady  out  1  allocation accepted this cycle.
- we  out  1  register status write enable.
- destRegR  out  REG+1  register status write index.
- destROB  out  ROB+1  allocated tag.
- commitReq  in  1  ROB head entry is complete.
- validCommit  out  1  commit occurring this cycle.
- commitROB  out  ROB+1  tag being committed.
- regCommit  out  REG+1  destination register of committing entry.
- commitRegWrite  out  1  committing entry writes a register.
- count  out  ROB+2  occupied entries, 0..2^(ROB+1).
- full  out  1  count == 2^(ROB+1).
- empty  out  1  count == 0.

Behaviour:
- N = 2^(ROB+1). State is head, tail (ROB+1 bits, wrap modulo N), count (ROB+2 bits), and a table of N entries `{regWrite, dest}`.
- Reset (`reset` = 0 at posedge):
  - head = tail = count = 0; table cleared.
  - While `reset` is low, combinationally renReady = we = validCommit = 0.
  - After reset: empty = 1, full = 0, count = 0.
- Allocation:
  - renReady = !full & !flush & reset.
  - allocFire = renValid & renReady.
  - Same cycle, combinational: destROB = tail; destRegR = renDest; we = allocFire & renRegWrite & (renDest != 0).
  - Same-cycle output is required because the status file writes on the following negedge.
  - At posedge on allocFire: table[tail] <= {renRegWrite & (renDest != 0), renDest}; tail++.
  - Dest x0 or renRegWrite = 0: a tag is still allocated but we stays 0.
- Commit:
  - validCommit = commitReq & !empty & reset.
  - Same cycle: commitROB = head; regCommit = table[head].dest; commitRegWrite = table[head].regWrite.
  - At posedge on validCommit: head++.
  - commitReq while empty: ignored, no state change.
- Count update at posedge:
  - +1 on allocFire only.
  - -1 on validCommit only.
  - Unchanged when both fire.
- Full with a simultaneous commit: allocation is still refused (full is based on registered count). No bypass.
- Empty with a simultaneous alloc: no commit. A new entry is never committable in its allocation cycle.
- Flush:
  - In the flush cycle, commit still proceeds and is reported (the committing instruction caused the flush); allocation is blocked.
  - At posedge: head = tail = count = 0, table cleared, identical to reset.
  - Flush and reset together: reset state.
- Wrap-around: tail 7 -> 0 and head 7 -> 0 are natural pointer overflow. Full/empty come only from count, never from pointer compare.
- Status outputs full, empty and count are registered-state derived, with no combinational path from inputs.

Decomposition:
- Package rob_pkg holds:
  - ROB_ENTRIES = 2^(ROB+1) and REG_COUNT constants;
  - typedefs rob_tag_t, reg_idx_t, rob_count_t;
  - packed struct rob_dest_entry_t {regWrite, dest}.
- One sub-module, rob_dest_table: N-entry register array with one write port (tail) and one asynchronous read port (head), plus a synchronous clear.
- Pointer/count logic and handshakes live in the top module.

Test Plan:
- Reset low 2 cycles, then high -> count = 0, empty = 1, renReady = 1; renValid = 1 with no commit -> destROB = 0 in cycle 1, 1 in cycle 2.
- Allocate 8 with renDest = 1..8, renRegWrite = 1 -> we = 1 each cycle, destROB = 0..7; then full = 1 and renReady = 0; a 9th renValid gets no allocation and tail stays 0.
- Full, then commitReq = 1 with renValid = 1 in the same cycle -> validCommit = 1, commitROB = 0, regCommit = 1, no allocation; next cycle count = 7 and allocation gives destROB = 0 (wrap).
- count = 3, alloc and commit in the same cycle -> count stays 3, head and tail both advance by 1.
- renDest = 0, renRegWrite = 1 -> we = 0, tag allocated; at commit commitRegWrite = 0.
- count = 4, flush = 1 with commitReq = 1 -> validCommit = 1 and renReady = 0 that cycle; next cycle count = 0, empty = 1, next allocation gives destROB = 0; repeat with reset low mid-stream -> same end state.

Source files
------------

// File: rtl/rob_tag_allocator_pkg.sv
// ROB tag allocator: shared widths, types and the destination table entry.
// Tags are a power-of-two ring, so pointer wrap is plain overflow.
package rob_pkg;

  localparam int REG = 4;
  localparam int ROB = 2;
  localparam int ROB_ENTRIES = 2 ** (ROB + 1);
  localparam int REG_COUNT = 2 ** (REG + 1);

  typedef logic [ROB:0] rob_tag_t;
  typedef logic [REG:0] reg_idx_t;
  typedef logic [ROB+1:0] rob_count_t;

  typedef struct packed {
    logic regWrite;
    reg_idx_t dest;
  } rob_dest_entry_t;

endpackage

// File: rtl/rob_tag_allocator_if.sv
// Rename-side and commit-side handshake bundle for the tag allocator.
// The master is the pipeline side, the slave is the allocator.
interface rob_tag_allocator_if;
  import rob_pkg::*;

  logic renValid;
  logic renRegWrite;
  reg_idx_t renDest;
  logic renReady;
  logic we;
  reg_idx_t destRegR;
  rob_tag_t destROB;
  logic commitReq;
  logic validCommit;
  rob_tag_t commitROB;
  reg_idx_t regCommit;
  logic commitRegWrite;

  modport master (
    output renValid, renRegWrite, renDest, commitReq,
    input renReady, we, destRegR, destROB,
    input validCommit, commitROB, regCommit, commitRegWrite
  );

  modport slave (
    input renValid, renRegWrite, renDest, commitReq,
    output renReady, we, destRegR, destROB,
    output validCommit, commitROB, regCommit, commitRegWrite
  );

endinterface

// File: rtl/rob_tag_allocator_dest_table.sv
// Per-tag destination table: one write port at tail, async read at head.
// A synchronous clear wipes every entry on reset or flush.
module rob_dest_table
  import rob_pkg::*;
(
  input logic clk,
  input logic clear,
  input logic wr_en,
  input rob_tag_t wr_idx,
  input rob_dest_entry_t wr_data,
  input rob_tag_t rd_idx,
  output rob_dest_entry_t rd_data
);

  rob_dest_entry_t mem [ROB_ENTRIES];

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < ROB_ENTRIES; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/rob_tag_allocator.sv
// ROB tag allocator: circular tag FIFO feeding the register status file.
// full/empty derive only from the registered count, never pointer compare.
module rob_tag_allocator
  import rob_pkg::*;
(
  input logic clk,
  input logic reset,
  input logic flush,
  rob_tag_allocator_if.slave bus,
  output rob_count_t count,
  output logic full,
  output logic empty
);

  rob_tag_t head;
  rob_tag_t tail;
  logic allocFire;
  logic clear;
  rob_dest_entry_t wr_entry;
  rob_dest_entry_t rd_entry;

  assign full = (count == rob_count_t'(ROB_ENTRIES));
  assign empty = (count == '0);
  assign clear = !reset || flush;

  assign bus.renReady = !full && !flush && reset;
  assign allocFire = bus.renValid && bus.renReady;

  // Status file writes on the following negedge, so these are same-cycle.
  assign bus.destROB = tail;
  assign bus.destRegR = bus.renDest;
  assign bus.we = allocFire && bus.renRegWrite && (bus.renDest != '0);

  assign wr_entry.regWrite = bus.renRegWrite && (bus.renDest != '0);
  assign wr_entry.dest = bus.renDest;

  assign bus.validCommit = bus.commitReq && !empty && reset;
  assign bus.commitROB = head;
  assign bus.regCommit = rd_entry.dest;
  assign bus.commitRegWrite = rd_entry.regWrite;

  always_ff @(posedge clk) begin
    if (clear) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (allocFire) tail <= tail + rob_tag_t'(1);
      if (bus.validCommit) head <= head + rob_tag_t'(1);
      unique case ({allocFire, bus.validCommit})
        2'b10: count <= count + rob_count_t'(1);
        2'b01: count <= count - rob_count_t'(1);
        default: count <= count;
      endcase
    end
  end

  rob_dest_table u_table (
    .clk(clk),
    .clear(clear),
    .wr_en(allocFire),
    .wr_idx(tail),
    .wr_data(wr_entry),
    .rd_idx(head),
    .rd_data(rd_entry)
  );

endmodule

// File: tb/tb_rob_tag_allocator.sv
// Bench for rob_tag_allocator: directed scenarios plus random traffic
// checked against a queue-based model of the tag ring.
module tb_rob_tag_allocator;

  typedef struct {
    bit rw;
    bit [4:0] dest;
  } ent_t;

  logic clk;
  logic rst_n;
  logic flush;
  logic [3:0] count;
  logic full;
  logic empty;

  rob_tag_allocator_if bus ();

  rob_tag_allocator dut (
    .clk(clk),
    .reset(rst_n),
    .flush(flush),
    .bus(bus),
    .count(count),
    .full(full),
    .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  ent_t q[$];
  int mhead = 0;
  int mtail = 0;
  bit inited = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit f, input bit rv,
                      input bit rrw, input bit [4:0] rd, input bit cr);
    bit exp_full;
    bit exp_ready;
    bit fire;
    bit exp_vc;
    ent_t e;
    rst_n = r;
    flush = f;
    bus.renValid = rv;
    bus.renRegWrite = rrw;
    bus.renDest = rd;
    bus.commitReq = cr;
    #3;
    exp_full = (q.size() == 8);
    exp_ready = r && !f && !exp_full;
    fire = rv && exp_ready;
    exp_vc = cr && r && (q.size() > 0);
    chk("renReady", 32'(bus.renReady), 32'(exp_ready));
    chk("we", 32'(bus.we), 32'(fire && rrw && rd != 0));
    chk("validCommit", 32'(bus.validCommit), 32'(exp_vc));
    if (inited) begin
      chk("destROB", 32'(bus.destROB), 32'(mtail));
      chk("destRegR", 32'(bus.destRegR), 32'(rd));
      chk("count", 32'(count), 32'(q.size()));
      chk("full", 32'(full), 32'(exp_full));
      chk("empty", 32'(empty), 32'(q.size() == 0));
    end
    if (exp_vc) begin
      chk("commitROB", 32'(bus.commitROB), 32'(mhead));
      chk("regCommit", 32'(bus.regCommit), 32'(q[0].dest));
      chk("commitRegWrite", 32'(bus.commitRegWrite), 32'(q[0].rw));
    end
    if (!r || f) begin
      q.delete();
      mhead = 0;
      mtail = 0;
      inited = 1;
    end else begin
      if (exp_vc) begin
        void'(q.pop_front());
        mhead = (mhead + 1) % 8;
      end
      if (fire) begin
        e.rw = rrw && (rd != 0);
        e.dest = rd;
        q.push_back(e);
        mtail = (mtail + 1) % 8;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    bus.renValid = 1'b0;
    bus.renRegWrite = 1'b0;
    bus.renDest = '0;
    bus.commitReq = 1'b0;
    @(posedge clk);
    #1;
    // reset held with live requests: outputs must stay quiet
    step(0, 0, 1, 1, 5'd3, 1);
    step(0, 0, 1, 1, 5'd3, 1);
    // fill all eight tags, then a refused ninth
    for (int i = 0; i < 8; i++) step(1, 0, 1, 1, 5'(i + 1), 0);
    step(1, 0, 1, 1, 5'd9, 0);
    chk("full_after_fill", 32'(full), 32'd1);
    // full plus commit: commit only, then wrap allocation
    step(1, 0, 1, 1, 5'd10, 1);
    step(1, 0, 1, 1, 5'd11, 0);
    // drain down to three entries
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 5'd0, 1);
    chk("count_three", 32'(count), 32'd3);
    // simultaneous alloc and commit keeps count
    step(1, 0, 1, 1, 5'd12, 1);
    chk("count_hold", 32'(count), 32'd3);
    // x0 destination and no-write allocations
    step(1, 0, 1, 1, 5'd0, 0);
    step(1, 0, 1, 0, 5'd7, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 5'd0, 1);
    // commit while empty is ignored
    step(1, 0, 0, 0, 5'd0, 1);
    // flush at count four with a commit
    for (int i = 0; i < 4; i++) step(1, 0, 1, 1, 5'(i + 20), 0);
    step(1, 1, 1, 1, 5'd25, 1);
    chk("empty_after_flush", 32'(empty), 32'd1);
    step(1, 0, 1, 1, 5'd26, 0);
    // same again with reset instead of flush
    for (int i = 0; i < 3; i++) step(1, 0, 1, 1, 5'(i + 27), 0);
    step(0, 1, 1, 1, 5'd30, 1);
    step(1, 0, 1, 1, 5'd31, 0);
    // random traffic with occasional flush and reset
    for (int n = 0; n < 600; n++) begin
      step(($urandom % 60) != 0, ($urandom % 40) == 0,
           ($urandom % 3) != 0, ($urandom % 4) != 0,
           5'($urandom % 32), ($urandom % 2) == 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
